pipe_stage_buf: RTL and testbench

- Inter-stage pipeline buffer; the responder end of the stage-buffer handshake that pipeline stages drive with buf_we/buf_re and sample via buf_wack/buf_rack/buf_avail.
- Upstream stage (e.g. IF, or the decoder on its output side) writes a payload bundle in; downstream stage (decoder, EX) reads it out.
- Small circular FIFO of DEPTH entries with one-cycle acknowledge pulses, an availability level for edge-triggered consumers, and a flush for branch/jump squash.

---
 rtl/pipe_stage_buf.sv | 138 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Inter-stage pipeline buffer. An upstream stage pushes payload bundles in
// with a level request / pulse acknowledge handshake. A downstream stage
// pulls them out with the same handshake. Storage is a small circular FIFO.
// An availability level lets edge-triggered consumers see one rising edge
// per refill. A synchronous flush squashes every entry on a branch or jump.
//
// Parameters
//   PAYLOAD_W  payload width in bits (e.g. {pc, inst} for IF/ID)
//   DEPTH      number of entries; must be a power of two and >= 2
//   PTR_W      pointer width, derived from DEPTH (not overridable)
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst      in   asynchronous, active-high reset
//   flush    in   synchronous squash of all entries
//   wr_req   in   write request, level, held until wr_ack
//   din      in   write payload, sampled in the accept cycle
//   wr_ack   out  one-cycle write-accept pulse
//   rd_req   in   read request, level, held until rd_ack
//   dout     out  read payload, valid from rd_ack until the next read
//   rd_ack   out  one-cycle read-accept pulse
//   avail    out  high while count != 0
//   full     out  high while count == DEPTH
//   count    out  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter  int PAYLOAD_W = 64,
    parameter  int DEPTH     = 2,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_req,
    input  logic [PAYLOAD_W-1:0] din,
    output logic                 wr_ack,
    input  logic                 rd_req,
    output logic [PAYLOAD_W-1:0] dout,
    output logic                 rd_ack,
    output logic                 avail,
    output logic                 full,
    output logic [PTR_W:0]       count
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    // Storage and state
    logic [PAYLOAD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic                 r_wr_ack;
    logic                 r_rd_ack;
    logic [PAYLOAD_W-1:0] r_dout;

    // Decodes of the registered count
    logic w_full;
    logic w_avail;
    logic w_wr_accept;
    logic w_rd_accept;

    // avail/full come only from the count register, so they cannot glitch.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_avail = (r_count != '0);

    // A request is ignored while its own ack is high. A requester that
    // drops its request on seeing the ack can never be accepted twice.
    // The ack pulse also cannot stretch to two cycles.
    // A write is refused while full, even if a read leaves this cycle.
    // A read is refused while empty, so there is no write-to-read bypass.
    assign w_wr_accept = wr_req && !r_wr_ack && !w_full  && !flush;
    assign w_rd_accept = rd_req && !r_rd_ack && w_avail && !flush;

    // NOTE: the storage array has no reset. Its contents are never observed
    // before being written, because a read needs count > 0. Leaving it
    // unreset keeps it a plain RAM/register file rather than DEPTH resettable flops.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // NOTE: every register below uses non-blocking assignment. The accept
    // terms above are then all evaluated from pre-edge state, so count,
    // pointers and acks update consistently within the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_ack <= 1'b0;
            r_rd_ack <= 1'b0;
            r_dout   <= '0;
        end else begin
            // The accept terms are forced low during flush. Any ack already
            // high therefore falls on schedule, and no new one is raised.
            r_wr_ack <= w_wr_accept;
            r_rd_ack <= w_rd_accept;

            if (flush) begin
                // Squash all entries. dout deliberately holds its last value.
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                // DEPTH is a power of two, so pointer wrap is natural overflow.
                if (w_wr_accept) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end

                if (w_rd_accept) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    r_dout   <= r_mem[r_rd_ptr];
                end

                // A simultaneous read and write leave the occupancy unchanged.
                unique case ({w_wr_accept, w_rd_accept})
                    2'b10:   r_count <= r_count + COUNT_ONE;
                    2'b01:   r_count <= r_count - COUNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign wr_ack = r_wr_ack;
    assign rd_ack = r_rd_ack;
    assign dout   = r_dout;
    assign count  = r_count;
    assign avail  = w_avail;
    assign full   = w_full;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Directed testbench for pipe_stage_buf with DEPTH=2 and PAYLOAD_W=64.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the
// same point. Every expected value below is worked out by hand from the
// handshake rules.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int PAYLOAD_W = 64;
    localparam int DEPTH     = 2;
    localparam int PTR_W     = $clog2(DEPTH);

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic                 wr_req;
    logic [PAYLOAD_W-1:0] din;
    logic                 wr_ack;
    logic                 rd_req;
    logic [PAYLOAD_W-1:0] dout;
    logic                 rd_ack;
    logic                 avail;
    logic                 full;
    logic [PTR_W:0]       count;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_buf #(
        .PAYLOAD_W (PAYLOAD_W),
        .DEPTH     (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .wr_req (wr_req),
        .din    (din),
        .wr_ack (wr_ack),
        .rd_req (rd_req),
        .dout   (dout),
        .rd_ack (rd_ack),
        .avail  (avail),
        .full   (full),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write with a bounded wait. The buffer is never full when this is
    // called, so the ack must come exactly one cycle after the request.
    task automatic do_write(input logic [63:0] d, input string tag);
        int n;
        n      = 0;
        wr_req = 1'b1;
        din    = d;
        do begin
            tick();
            n++;
        end while (!wr_ack && n < 20);
        check({tag, "_wr_ack"}, 64'(wr_ack), 64'd1);
        check({tag, "_wr_lat"}, 64'(n), 64'd1);
        wr_req = 1'b0;
        tick();
        check({tag, "_wr_ack_fall"}, 64'(wr_ack), 64'd0);
    endtask

    // Read with a bounded wait. The buffer always holds data when this is
    // called, so the ack must come exactly one cycle after the request.
    task automatic do_read(input logic [63:0] exp, input string tag);
        int n;
        n      = 0;
        rd_req = 1'b1;
        do begin
            tick();
            n++;
        end while (!rd_ack && n < 20);
        check({tag, "_rd_ack"}, 64'(rd_ack), 64'd1);
        check({tag, "_rd_lat"}, 64'(n), 64'd1);
        check({tag, "_dout"}, dout, exp);
        rd_req = 1'b0;
        tick();
        check({tag, "_rd_ack_fall"}, 64'(rd_ack), 64'd0);
        check({tag, "_dout_hold"}, dout, exp);
    endtask

    initial begin
        logic prev_wr;
        logic prev_rd;

        rst    = 1'b1;
        flush  = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        din    = '0;

        // ---------------- reset state ----------------
        #23;
        check("rst_wr_ack", 64'(wr_ack), 64'd0);
        check("rst_rd_ack", 64'(rd_ack), 64'd0);
        check("rst_dout",   dout,        64'd0);
        check("rst_count",  64'(count),  64'd0);
        check("rst_avail",  64'(avail),  64'd0);
        check("rst_full",   64'(full),   64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_count", 64'(count), 64'd0);

        // ---------------- single write then read ----------------
        wr_req = 1'b1;
        din    = 64'h0000_0004_0000_0013;
        tick();
        check("t1_wr_ack", 64'(wr_ack), 64'd1);
        check("t1_count",  64'(count),  64'd1);
        check("t1_avail",  64'(avail),  64'd1);
        wr_req = 1'b0;
        tick();
        check("t1_wr_ack_fall", 64'(wr_ack), 64'd0);
        rd_req = 1'b1;
        tick();
        check("t1_rd_ack", 64'(rd_ack), 64'd1);
        check("t1_dout",   dout,        64'h0000_0004_0000_0013);
        check("t1_count0", 64'(count),  64'd0);
        check("t1_avail0", 64'(avail),  64'd0);
        rd_req = 1'b0;
        tick();
        check("t1_rd_ack_fall", 64'(rd_ack), 64'd0);

        // ---------------- fill, blocked write, wrap ordering ----------------
        do_write(64'h1, "t2_A");
        do_write(64'h2, "t2_B");
        check("t2_full",  64'(full),  64'd1);
        check("t2_count", 64'(count), 64'd2);
        wr_req = 1'b1;
        din    = 64'h3;
        tick();
        check("t2_C_blocked1", 64'(wr_ack), 64'd0);
        tick();
        check("t2_C_blocked2", 64'(wr_ack), 64'd0);
        // Read while full: the read is accepted, the write still is not.
        rd_req = 1'b1;
        tick();
        check("t2_rd_ack",     64'(rd_ack), 64'd1);
        check("t2_dout_A",     dout,        64'h1);
        check("t2_C_blocked3", 64'(wr_ack), 64'd0);
        check("t2_count1",     64'(count),  64'd1);
        check("t2_full0",      64'(full),   64'd0);
        rd_req = 1'b0;
        tick();
        check("t2_C_wr_ack", 64'(wr_ack), 64'd1);
        check("t2_count2",   64'(count),  64'd2);
        wr_req = 1'b0;
        tick();
        do_read(64'h2, "t2_B");
        do_read(64'h3, "t2_C");
        check("t2_empty", 64'(count), 64'd0);

        // ---------------- simultaneous read/write at count=1 ----------------
        do_write(64'h44, "t3_D");
        wr_req = 1'b1;
        rd_req = 1'b1;
        din    = 64'h55;
        tick();
        check("t3_wr_ack", 64'(wr_ack), 64'd1);
        check("t3_rd_ack", 64'(rd_ack), 64'd1);
        check("t3_count",  64'(count),  64'd1);
        check("t3_dout",   dout,        64'h44);
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick();
        do_read(64'h55, "t3_E");

        // ---------------- simultaneous requests on empty buffer ----------------
        wr_req = 1'b1;
        rd_req = 1'b1;
        din    = 64'h66;
        tick();
        check("t4_wr_ack1", 64'(wr_ack), 64'd1);
        check("t4_rd_ack1", 64'(rd_ack), 64'd0);
        check("t4_count1",  64'(count),  64'd1);
        tick();
        check("t4_wr_ack2", 64'(wr_ack), 64'd0);
        check("t4_rd_ack2", 64'(rd_ack), 64'd1);
        check("t4_dout",    dout,        64'h66);
        check("t4_count2",  64'(count),  64'd0);
        // Requests held: acks alternate and never stay high two cycles.
        prev_wr = wr_ack;
        prev_rd = rd_ack;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_no_consec_wr", 64'(wr_ack & prev_wr), 64'd0);
            check("t4_no_consec_rd", 64'(rd_ack & prev_rd), 64'd0);
            prev_wr = wr_ack;
            prev_rd = rd_ack;
        end
        check("t4_final_rd_ack", 64'(rd_ack), 64'd1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick();
        check("t4_drained", 64'(count), 64'd0);

        // ---------------- flush with pending write ----------------
        do_write(64'h77, "t5_G");
        do_write(64'h88, "t5_H");
        check("t5_count2", 64'(count), 64'd2);
        wr_req = 1'b1;
        din    = 64'h99;
        flush  = 1'b1;
        tick();
        check("t5_flush_count",  64'(count),  64'd0);
        check("t5_flush_avail",  64'(avail),  64'd0);
        check("t5_flush_wr_ack", 64'(wr_ack), 64'd0);
        check("t5_flush_dout",   dout,        64'h66);
        flush = 1'b0;
        tick();
        check("t5_post_wr_ack", 64'(wr_ack), 64'd1);
        check("t5_post_count",  64'(count),  64'd1);
        wr_req = 1'b0;
        tick();
        do_read(64'h99, "t5_J");

        // ---------------- asynchronous reset mid-ack ----------------
        wr_req = 1'b1;
        din    = 64'hAA;
        tick();
        check("t6_wr_ack_pre", 64'(wr_ack), 64'd1);
        check("t6_count_pre",  64'(count),  64'd1);
        wr_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_wr_ack", 64'(wr_ack), 64'd0);
        check("t6_async_rd_ack", 64'(rd_ack), 64'd0);
        check("t6_async_count",  64'(count),  64'd0);
        check("t6_async_avail",  64'(avail),  64'd0);
        check("t6_async_dout",   dout,        64'd0);
        #3;
        rst = 1'b0;
        tick();
        check("t6_after_wr_ack", 64'(wr_ack), 64'd0);
        check("t6_after_count",  64'(count),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
